// File: rtl/uart_blk_pkg.sv
// rtl/uart_blk_pkg.sv - shared types and defaults for the UART block controller
// Purpose: RX/TX state enums, default NBYTES/TIMEOUT_CYC and a saturating
//          8-bit increment used by the error counter.
package uart_blk_pkg;

    localparam int DEF_NBYTES      = 8;
    localparam int DEF_TIMEOUT_CYC = 65535;

    typedef enum logic {
        R_COLLECT = 1'b0,
        R_PRESENT = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_WR      = 2'd1,
        T_WAIT_HI = 2'd2,
        T_WAIT_LO = 2'd3
    } tx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_blk_tx_seq.sv
// rtl/uart_blk_tx_seq.sv - block-to-UART transmit sequencer
// Purpose: takes one NBYTES block and writes it to the UART MSB byte first,
//          one tx_wr strobe per byte, pacing on tx_busy.
// Ports:   clk, n_reset (async, active-low)
//          blk_in/blk_in_valid/blk_in_ready - block handshake
//          tx_data/tx_wr/tx_busy             - UART transmit side
// All outputs are registered.
module uart_blk_tx_seq
    import uart_blk_pkg::*;
#(
    parameter int NBYTES = DEF_NBYTES
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [8*NBYTES-1:0]   blk_in,
    input  logic                  blk_in_valid,
    output logic                  blk_in_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_busy
);

    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    tx_state_t              r_state, w_state_nx;
    logic [8*NBYTES-1:0]    r_shift, w_shift_nx;
    logic [IW-1:0]          r_idx, w_idx_nx;
    logic [7:0]             r_tx_data, w_tx_data_nx;
    logic                   r_tx_wr, w_tx_wr_nx;
    logic                   r_ready, w_ready_nx;

    always_comb begin
        w_state_nx   = r_state;
        w_shift_nx   = r_shift;
        w_idx_nx     = r_idx;
        w_tx_data_nx = r_tx_data;
        w_tx_wr_nx   = 1'b0;
        case (r_state)
            // Capture only when ready is already visible, so the first
            // cycle after reset (ready still 0) cannot swallow a block.
            T_IDLE: begin
                if (r_ready && blk_in_valid) begin
                    w_shift_nx = blk_in;
                    w_idx_nx   = '0;
                    w_state_nx = T_WR;
                end
            end
            T_WR: begin
                if (!tx_busy) begin
                    w_tx_data_nx = r_shift[8*NBYTES-1 -: 8];
                    w_tx_wr_nx   = 1'b1;
                    w_state_nx   = T_WAIT_HI;
                end
            end
            T_WAIT_HI: begin
                if (tx_busy) begin
                    w_state_nx = T_WAIT_LO;
                end
            end
            T_WAIT_LO: begin
                if (!tx_busy) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nx = T_IDLE;
                    end else begin
                        w_shift_nx = r_shift << 8;
                        w_idx_nx   = r_idx + IW'(1);
                        w_state_nx = T_WR;
                    end
                end
            end
            default: w_state_nx = T_IDLE;
        endcase
        w_ready_nx = (w_state_nx == T_IDLE);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= T_IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_tx_data <= 8'h00;
            r_tx_wr   <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_shift   <= w_shift_nx;
            r_idx     <= w_idx_nx;
            r_tx_data <= w_tx_data_nx;
            r_tx_wr   <= w_tx_wr_nx;
            r_ready   <= w_ready_nx;
        end
    end

    assign blk_in_ready = r_ready;
    assign tx_data      = r_tx_data;
    assign tx_wr        = r_tx_wr;

endmodule

// File: rtl/uart_blk_ctrl.sv
// rtl/uart_blk_ctrl.sv - UART byte stream to fixed-size block controller
// Purpose: RX assembles NBYTES UART bytes (MSB first) into blk_out and holds
//          it until blk_out_ready; framing errors drop the partial block and
//          bump a saturating err_cnt. TX is delegated to uart_blk_tx_seq.
// Ports:   clk, n_reset (async, active-low)
//          rx_data/rx_avail/rx_error/rx_ack   - UART receive side
//          tx_data/tx_wr/tx_busy              - UART transmit side
//          blk_out/blk_out_valid/blk_out_ready - assembled block out
//          blk_in/blk_in_valid/blk_in_ready    - block to transmit
//          err_cnt                             - discarded partial blocks
// Option:  UART_BLK_CTRL_TIMEOUT_EN enables the inter-byte timeout.
module uart_blk_ctrl
    import uart_blk_pkg::*;
#(
    parameter int NBYTES      = DEF_NBYTES,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_avail,
    input  logic                  rx_error,
    output logic                  rx_ack,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_busy,
    output logic [8*NBYTES-1:0]   blk_out,
    output logic                  blk_out_valid,
    input  logic                  blk_out_ready,
    input  logic [8*NBYTES-1:0]   blk_in,
    input  logic                  blk_in_valid,
    output logic                  blk_in_ready,
    output logic [7:0]            err_cnt
);

    localparam int CW = $clog2(NBYTES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);

    if (NBYTES < 2 || NBYTES > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("uart_blk_ctrl: NBYTES or TIMEOUT_CYC out of range");
    end

    rx_state_t              r_rx_state, w_rx_state_nx;
    logic [CW-1:0]          r_cnt, w_cnt_nx;
    logic [8*NBYTES-1:0]    r_blk_out, w_blk_nx;
    logic                   r_blk_out_valid, w_valid_nx;
    logic                   r_rx_ack, w_ack_nx;
    logic [7:0]             r_err_cnt, w_err_nx;
`ifdef UART_BLK_CTRL_TIMEOUT_EN
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYC);
    logic [15:0]            r_to_cnt, w_to_nx;
`endif

    // r_rx_ack gates acceptance: the UART only drops rx_avail/rx_error
    // once it has seen the ack, so the ack cycle must not count twice.
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_cnt_nx      = r_cnt;
        w_blk_nx      = r_blk_out;
        w_valid_nx    = r_blk_out_valid;
        w_ack_nx      = 1'b0;
        w_err_nx      = r_err_cnt;
`ifdef UART_BLK_CTRL_TIMEOUT_EN
        w_to_nx       = r_to_cnt;
`endif
        case (r_rx_state)
            R_COLLECT: begin
                if (rx_error && !r_rx_ack) begin
                    w_ack_nx = 1'b1;
                    w_cnt_nx = '0;
                    if (r_cnt != '0) begin
                        w_err_nx = sat_inc8(r_err_cnt);
                    end
`ifdef UART_BLK_CTRL_TIMEOUT_EN
                    w_to_nx  = 16'd0;
`endif
                end else if (rx_avail && !r_rx_ack) begin
                    w_ack_nx = 1'b1;
                    // Shifting in at the bottom leaves the first byte on top.
                    w_blk_nx = {r_blk_out[8*NBYTES-9:0], rx_data};
`ifdef UART_BLK_CTRL_TIMEOUT_EN
                    w_to_nx  = 16'd0;
`endif
                    if (r_cnt == LAST_CNT) begin
                        w_cnt_nx      = '0;
                        w_valid_nx    = 1'b1;
                        w_rx_state_nx = R_PRESENT;
                    end else begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end
                end
`ifdef UART_BLK_CTRL_TIMEOUT_EN
                else if (r_cnt != '0) begin
                    if (r_to_cnt == TO_LIM) begin
                        w_cnt_nx = '0;
                        w_err_nx = sat_inc8(r_err_cnt);
                        w_to_nx  = 16'd0;
                    end else begin
                        w_to_nx  = r_to_cnt + 16'd1;
                    end
                end
`endif
            end
            R_PRESENT: begin
                if (blk_out_ready) begin
                    w_valid_nx    = 1'b0;
                    w_rx_state_nx = R_COLLECT;
                end
            end
            default: w_rx_state_nx = R_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_rx_state      <= R_COLLECT;
            r_cnt           <= '0;
            r_blk_out       <= '0;
            r_blk_out_valid <= 1'b0;
            r_rx_ack        <= 1'b0;
            r_err_cnt       <= 8'h00;
`ifdef UART_BLK_CTRL_TIMEOUT_EN
            r_to_cnt        <= 16'd0;
`endif
        end else begin
            r_rx_state      <= w_rx_state_nx;
            r_cnt           <= w_cnt_nx;
            r_blk_out       <= w_blk_nx;
            r_blk_out_valid <= w_valid_nx;
            r_rx_ack        <= w_ack_nx;
            r_err_cnt       <= w_err_nx;
`ifdef UART_BLK_CTRL_TIMEOUT_EN
            r_to_cnt        <= w_to_nx;
`endif
        end
    end

    uart_blk_tx_seq #(
        .NBYTES       (NBYTES)
    ) u_tx (
        .clk          (clk),
        .n_reset      (n_reset),
        .blk_in       (blk_in),
        .blk_in_valid (blk_in_valid),
        .blk_in_ready (blk_in_ready),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx_busy      (tx_busy)
    );

    assign rx_ack        = r_rx_ack;
    assign blk_out       = r_blk_out;
    assign blk_out_valid = r_blk_out_valid;
    assign err_cnt       = r_err_cnt;

endmodule
